// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared burst geometry, training constants and FSM state type for the OFDM transmit path
package ofdm_tx_pkg;
  localparam int ACTIVE_SUBCARR = 28;
  localparam int SYMBOL_NUM = 8;
  localparam int CHANNEL_EST_NUM = 4;
  localparam int DATA_LEN = ACTIVE_SUBCARR * SYMBOL_NUM;
  localparam int CEST_LEN = ACTIVE_SUBCARR * CHANNEL_EST_NUM;
  localparam logic [7:0] CEST_AMP = 8'd64;
  localparam logic [27:0] CEST_PATTERN = 28'h5A3C96E;
  typedef enum logic [1:0] {ST_FILL, ST_CEST, ST_DATA} state_e;
endpackage

// File: rtl/cest_seq_rom.sv
// cest_seq_rom: subcarrier index to signed training value (+AMP where the pattern bit is set, -AMP otherwise)
module cest_seq_rom
  import ofdm_tx_pkg::*;
#(
  parameter logic [7:0] AMP = CEST_AMP,
  parameter logic [27:0] PATTERN = CEST_PATTERN
) (
  input  logic [4:0] sc_i,
  output logic [7:0] val_o
);
  logic [31:0] pat;
  assign pat = {4'd0, PATTERN};
  assign val_o = pat[sc_i] ? AMP : (~AMP + 8'd1);
endmodule

// File: rtl/ofdm_burst_builder.sv
// ofdm_burst_builder: buffers one burst of data subcarriers, then streams training symbols followed by the data.
// A producer runs ahead of the output register through a 1-cycle read stage and a 2-entry skid FIFO.
module ofdm_burst_builder
  import ofdm_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        wren,
  output logic        in_ready,
  output logic        drop,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        frame_done
);
  state_e state_q, state_d;
  logic [7:0] cnt_in_q, cnt_in_d, out_cnt_q, out_cnt_d, rd_addr_q, rd_addr_d;
  logic [4:0] sc_q, sc_d;
  logic [1:0] sym_q, sym_d, fcnt_q, fcnt_nx;
  logic gen_cest_q, gen_cest_d, gen_done_q, gen_done_d;
  logic p1_v_q, p1_cest_q, fwr_q, frd_q;
  logic [7:0] p1_cv_q, rom_val;
  logic [15:0] fifo_q [2];
  logic [15:0] mem [DATA_LEN];
  logic [15:0] ram_q, p1_dat, dout_q;
  logic dout_valid_q, drop_q, frame_done_q;
  logic xfer, load, fifo_ne, pop, fpop, push, issue, cest_iss, data_iss, sc_wrap;
  logic wr_en, last_wr, last_cest, last_data;

  cest_seq_rom u_rom (.sc_i(sc_q), .val_o(rom_val));

  assign xfer = dout_valid_q && dout_ready;
  assign load = !dout_valid_q || dout_ready;
  assign p1_dat = p1_cest_q ? {8'h00, p1_cv_q} : ram_q;
  assign fifo_ne = fcnt_q != 2'd0;
  assign pop = load && (fifo_ne || p1_v_q);
  assign fpop = pop && fifo_ne;
  assign push = p1_v_q && !(pop && !fifo_ne);
  assign fcnt_nx = fcnt_q + 2'(push) - 2'(fpop);
  // Issue only when the item landing in the read stage is guaranteed a FIFO slot next cycle.
  assign issue = state_q != ST_FILL && !gen_done_q && fcnt_nx <= 2'd1;
  assign cest_iss = issue && gen_cest_q;
  assign data_iss = issue && !gen_cest_q;
  assign sc_wrap = sc_q == 5'(ACTIVE_SUBCARR - 1);
  assign wr_en = wren && state_q == ST_FILL;
  assign last_wr = wr_en && cnt_in_q == 8'(DATA_LEN - 1);
  assign last_cest = xfer && state_q == ST_CEST && out_cnt_q == 8'(CEST_LEN - 1);
  assign last_data = xfer && state_q == ST_DATA && out_cnt_q == 8'(DATA_LEN - 1);

  always_comb begin
    state_d = last_wr ? ST_CEST : last_cest ? ST_DATA : last_data ? ST_FILL : state_q;
    cnt_in_d = last_wr ? 8'd0 : wr_en ? cnt_in_q + 8'd1 : cnt_in_q;
    out_cnt_d = (last_cest || last_data) ? 8'd0 : xfer ? out_cnt_q + 8'd1 : out_cnt_q;
    sc_d = last_data ? 5'd0 : cest_iss ? (sc_wrap ? 5'd0 : sc_q + 5'd1) : sc_q;
    sym_d = last_data ? 2'd0 : (cest_iss && sc_wrap) ? sym_q + 2'd1 : sym_q;
    gen_cest_d = last_data ? 1'b1
               : (cest_iss && sc_wrap && sym_q == 2'(CHANNEL_EST_NUM - 1)) ? 1'b0 : gen_cest_q;
    rd_addr_d = last_data ? 8'd0 : data_iss ? rd_addr_q + 8'd1 : rd_addr_q;
    gen_done_d = last_data ? 1'b0 : (data_iss && rd_addr_q == 8'(DATA_LEN - 1)) ? 1'b1 : gen_done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_in_q <= '0;
      out_cnt_q <= '0;
      rd_addr_q <= '0;
      sc_q <= '0;
      sym_q <= '0;
      gen_cest_q <= 1'b1;
      gen_done_q <= 1'b0;
      p1_v_q <= 1'b0;
      p1_cest_q <= 1'b0;
      p1_cv_q <= '0;
      fcnt_q <= '0;
      fwr_q <= 1'b0;
      frd_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      drop_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_in_q <= cnt_in_d;
      out_cnt_q <= out_cnt_d;
      rd_addr_q <= rd_addr_d;
      sc_q <= sc_d;
      sym_q <= sym_d;
      gen_cest_q <= gen_cest_d;
      gen_done_q <= gen_done_d;
      p1_v_q <= issue;
      p1_cest_q <= issue ? gen_cest_q : p1_cest_q;
      p1_cv_q <= issue ? rom_val : p1_cv_q;
      fcnt_q <= fcnt_nx;
      fwr_q <= fwr_q ^ push;
      frd_q <= frd_q ^ fpop;
      dout_q <= pop ? (fifo_ne ? fifo_q[frd_q] : p1_dat) : dout_q;
      dout_valid_q <= load ? (fifo_ne || p1_v_q) : 1'b1;
      drop_q <= wren && state_q != ST_FILL;
      frame_done_q <= last_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_in_q] <= din;
    if (data_iss) ram_q <= mem[rd_addr_q];
    if (push) fifo_q[fwr_q] <= p1_dat;
  end

  assign in_ready = state_q == ST_FILL;
  assign drop = drop_q;
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ofdm_burst_builder.sv
// tb_ofdm_burst_builder: directed burst scenarios with random data/backpressure against a sample-order model
module tb_ofdm_burst_builder;
  logic clk = 1'b0, rst_n = 1'b0, wren = 1'b0, dout_ready = 1'b0;
  logic [15:0] din = '0;
  logic in_ready, drop, dout_valid, frame_done;
  logic [15:0] dout;
  int checks = 0, failures = 0, cyc = 0, drop_cnt = 0, fd_cnt = 0, wr_cyc = 0;
  int d0, f0;
  logic [15:0] data [224];
  logic [27:0] pat = 28'h5A3C96E;

  ofdm_burst_builder dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wren(wren), .in_ready(in_ready), .drop(drop),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (drop) drop_cnt++;
    if (frame_done) fd_cnt++;
  end

  function automatic logic [15:0] model(input int k);
    if (k < 112) return {8'h00, pat[k % 28] ? 8'h40 : 8'hC0};
    return data[k - 112];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_data(input bit rnd);
    for (int i = 0; i < 224; i++) data[i] = rnd ? 16'($urandom) : 16'h0100 + 16'(i);
  endtask

  // Caller must be at a negedge; the first write is driven immediately.
  task automatic write_burst(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        wren = 1'b0;
        chk("no_early_valid", dout_valid, 0);
        @(negedge clk);
      end
      if (i < 224) chk("no_early_valid", dout_valid, 0);
      wren = 1'b1;
      din = i < 224 ? data[i] : 16'($urandom);
      if (i == 223) wr_cyc = cyc;
      @(negedge clk);
    end
    wren = 1'b0;
  endtask

  task automatic read_burst(input bit rnd_ready, input int abort_at);
    int idx = 0, guard = 0, first = -1, last = 0, fd_seen = 0;
    int goal = abort_at >= 0 ? abort_at : 336;
    bit stall = 1'b0;
    logic [15:0] held = '0;
    while (idx < goal && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (frame_done) fd_seen++;
      if (stall) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_dout", dout, held);
      end
      if (dout_valid && first < 0) begin
        first = cyc;
        chk("first_valid_latency", {31'd0, (cyc - wr_cyc) <= 3}, 1);
      end
      dout_ready = rnd_ready ? 1'($urandom) : 1'b1;
      if (dout_valid && dout_ready) begin
        chk($sformatf("sample%0d", idx), dout, model(idx));
        idx++;
        last = cyc;
      end
      stall = dout_valid && !dout_ready;
      held = dout;
    end
    chk("burst_timeout", {31'd0, guard < 5000}, 1);
    chk("no_early_frame_done", fd_seen, 0);
    if (abort_at < 0) begin
      if (!rnd_ready) chk("contiguous_cycles", last - first + 1, 336);
      @(negedge clk);
      chk("frame_done_pulse", frame_done, 1);
      chk("in_ready_at_done", in_ready, 1);
      chk("valid_low_at_done", dout_valid, 0);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop", drop, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    // nominal
    fill_data(1'b0);
    dout_ready = 1'b1;
    d0 = drop_cnt;
    f0 = fd_cnt;
    fork
      write_burst(224, 1'b0);
      read_burst(1'b0, -1);
    join
    @(negedge clk);
    chk("nominal_frame_done_single", frame_done, 0);
    chk("nominal_fd_count", fd_cnt - f0, 1);
    chk("nominal_drops", drop_cnt - d0, 0);
    // backpressure
    f0 = fd_cnt;
    fork
      write_burst(224, 1'b0);
      read_burst(1'b1, -1);
    join
    @(negedge clk);
    dout_ready = 1'b1;
    chk("bp_fd_count", fd_cnt - f0, 1);
    // overflow
    fill_data(1'b1);
    d0 = drop_cnt;
    fork
      write_burst(230, 1'b0);
      read_burst(1'b0, -1);
    join
    @(negedge clk);
    chk("overflow_drops", drop_cnt - d0, 6);
    // reset during DATA
    fill_data(1'b1);
    fork
      write_burst(224, 1'b0);
      read_burst(1'b1, 162);
    join
    chk("in_ready_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_data(1'b1);
    fork
      write_burst(224, 1'b0);
      read_burst(1'b0, -1);
    join
    @(negedge clk);
    // idle gaps
    fill_data(1'b0);
    fork
      write_burst(224, 1'b1);
      read_burst(1'b0, -1);
    join
    @(negedge clk);
    // back-to-back: second burst writes begin the cycle frame_done is high
    fill_data(1'b1);
    d0 = drop_cnt;
    f0 = fd_cnt;
    fork
      write_burst(224, 1'b0);
      read_burst(1'b0, -1);
    join
    fill_data(1'b1);
    fork
      write_burst(224, 1'b0);
      read_burst(1'b1, -1);
    join
    @(negedge clk);
    chk("b2b_drops", drop_cnt - d0, 0);
    chk("b2b_fd_count", fd_cnt - f0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
